axi_slave_mem: RTL and testbench

- AXI slave endpoint: the responder that the team's Master drives; terminates all five channels in front of a word-addressed on-chip memory.
- Write path (AW/W/B) and read path (AR/R) are independent FSMs.
- Both paths run concurrently on one clock.
- Used as the bus-functional target for Master bring-up.

---
 rtl/axi_pkg.sv | 49 ++++
 rtl/axi_burst_addr.sv | 75 +++++++
 rtl/axi_slave_mem.sv | 185 ++++++++++++++++++
 tb/tb_axi_slave_mem.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// Shared types, widths and address helpers for the AXI slave memory.
package axi_pkg;
  localparam int DATAWIDTH  = 32;
  localparam int SIZE       = 3;
  localparam int IDW        = DATAWIDTH / 8;
  localparam int LENW       = DATAWIDTH / 8;
  localparam int STRBW      = DATAWIDTH / 8;
  localparam int BW         = SIZE - 1;
  localparam int RW         = SIZE - 1;
  localparam int CNTW       = LENW + 1;
  localparam int WORD_SHIFT = $clog2(DATAWIDTH / 8);
  localparam logic [SIZE-1:0] MAX_SIZE = SIZE'(WORD_SHIFT);

  typedef enum logic [BW-1:0] {
    B_SINGLE = 2'b00,
    B_INCR   = 2'b01,
    B_WRAP4  = 2'b10,
    B_INCR4  = 2'b11
  } burst_e;

  localparam logic [RW-1:0] RESP_OKAY   = 2'b00;
  localparam logic [RW-1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_e;
  typedef enum logic       {R_IDLE, R_DATA}         rstate_e;

  // Number of beats a burst carries; INCR honours LEN, the fixed bursts do not.
  function automatic logic [CNTW-1:0] beat_count(input logic [BW-1:0]   burst,
                                                 input logic [LENW-1:0] len);
    case (burst_e'(burst))
      B_SINGLE: return CNTW'(1);
      B_INCR:   return {1'b0, len} + CNTW'(1);
      default:  return CNTW'(4);
    endcase
  endfunction

  // Address of the beat after addr; WRAP4 folds back into the aligned window around start.
  function automatic logic [DATAWIDTH-1:0] next_addr(input logic [DATAWIDTH-1:0] addr,
                                                     input logic [SIZE-1:0]      size,
                                                     input logic [BW-1:0]        burst,
                                                     input logic [DATAWIDTH-1:0] start);
    logic [DATAWIDTH-1:0] step;
    logic [DATAWIDTH-1:0] mask;
    step = DATAWIDTH'(1) << size;
    mask = (step << 2) - DATAWIDTH'(1);
    if (burst == B_WRAP4) return (start & ~mask) | ((addr + step) & mask);
    return addr + step;
  endfunction
endpackage

// File: rtl/axi_burst_addr.sv
// Burst address and beat-count generator; one copy serves writes, one serves reads.
module axi_burst_addr
  import axi_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 adv,
  input  logic [DATAWIDTH-1:0] start_addr,
  input  logic [LENW-1:0]      len,
  input  logic [SIZE-1:0]      size,
  input  logic [BW-1:0]        burst,
  output logic [AW-1:0]        widx,
  output logic                 last,
  output logic                 beat_err
);
  localparam int IW = DATAWIDTH - WORD_SHIFT;

  logic [DATAWIDTH-1:0] addr_q, addr_d, start_q, start_d;
  logic [SIZE-1:0]      size_q, size_d;
  logic [BW-1:0]        burst_q, burst_d;
  logic [CNTW-1:0]      cnt_q, cnt_d, total_q, total_d;
  logic [IW-1:0]        widx_full;

  // Latch a new burst on load, otherwise step one beat per accepted transfer.
  always_comb begin
    addr_d  = addr_q;
    start_d = start_q;
    size_d  = size_q;
    burst_d = burst_q;
    cnt_d   = cnt_q;
    total_d = total_q;
    if (load) begin
      addr_d  = start_addr;
      start_d = start_addr;
      size_d  = size;
      burst_d = burst;
      cnt_d   = '0;
      total_d = beat_count(burst, len);
    end else if (adv) begin
      addr_d = next_addr(addr_q, size_q, burst_q, start_q);
      cnt_d  = cnt_q + CNTW'(1);
    end
  end

  // Burst state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      start_q <= '0;
      size_q  <= '0;
      burst_q <= '0;
      cnt_q   <= '0;
      total_q <= '0;
    end else begin
      addr_q  <= addr_d;
      start_q <= start_d;
      size_q  <= size_d;
      burst_q <= burst_d;
      cnt_q   <= cnt_d;
      total_q <= total_d;
    end
  end

  // Current beat decode: word index, final-beat flag, and out-of-range / oversize error.
  always_comb begin
    widx_full = addr_q[DATAWIDTH-1:WORD_SHIFT];
    widx      = widx_full[AW-1:0];
    last      = (cnt_q == total_q - CNTW'(1));
    beat_err  = (widx_full >= IW'(DEPTH)) || (size_q > MAX_SIZE);
  end
endmodule

// File: rtl/axi_slave_mem.sv
// AXI slave endpoint in front of a word-addressed memory; independent write and read FSMs.
// Handshake rule: a transfer happens on the rising edge where VALID and READY are both 1;
// a source never drops VALID or changes its payload until that edge.
module axi_slave_mem
  import axi_pkg::*;
#(
  parameter int DEPTH = 256
) (
  input  logic                 ACLK,
  input  logic                 ARESET,
  input  logic                 AWVALID,
  output logic                 AWREADY,
  input  logic [IDW-1:0]       AWID,
  input  logic [DATAWIDTH-1:0] AWADDR,
  input  logic [LENW-1:0]      AWLEN,
  input  logic [SIZE-1:0]      AWSIZE,
  input  logic [BW-1:0]        AWBURST,
  input  logic                 WVALID,
  output logic                 WREADY,
  input  logic [IDW-1:0]       WID,
  input  logic [DATAWIDTH:0]   WDATA,
  input  logic [STRBW-1:0]     WSTRB,
  input  logic                 WLAST,
  output logic                 BVALID,
  input  logic                 BREADY,
  output logic [IDW-1:0]       BID,
  output logic [RW-1:0]        BRESP,
  input  logic                 ARVALID,
  output logic                 ARREADY,
  input  logic [IDW-1:0]       ARID,
  input  logic [DATAWIDTH-1:0] ARADDR,
  input  logic [LENW-1:0]      ARLEN,
  input  logic [SIZE-1:0]      ARSIZE,
  input  logic [BW-1:0]        ARBURST,
  output logic                 RVALID,
  input  logic                 RREADY,
  output logic [IDW-1:0]       RID,
  output logic [DATAWIDTH-1:0] RDATA,
  output logic [RW-1:0]        RRESP,
  output logic                 RLAST
);
  localparam int AW = $clog2(DEPTH);

  logic [DATAWIDTH-1:0] mem_q [DEPTH];

  wstate_e        w_state_q, w_state_d;
  rstate_e        r_state_q, r_state_d;
  logic [IDW-1:0] awid_q, awid_d, arid_q, arid_d;
  logic           werr_q, werr_d, drain_q, drain_d;
  logic           aw_load, w_adv, mem_we, ar_load, r_adv;
  logic [AW-1:0]  w_widx, r_widx;
  logic           w_last, w_err, r_last, r_err;
  logic           unused_wbits;

  // WID and the spare top data bit carry nothing this memory uses.
  assign unused_wbits = ^{WID, WDATA[DATAWIDTH]};

  axi_burst_addr #(.DEPTH(DEPTH), .AW(AW)) u_waddr (
    .clk(ACLK), .rst(ARESET), .load(aw_load), .adv(w_adv),
    .start_addr(AWADDR), .len(AWLEN), .size(AWSIZE), .burst(AWBURST),
    .widx(w_widx), .last(w_last), .beat_err(w_err)
  );

  axi_burst_addr #(.DEPTH(DEPTH), .AW(AW)) u_raddr (
    .clk(ACLK), .rst(ARESET), .load(ar_load), .adv(r_adv),
    .start_addr(ARADDR), .len(ARLEN), .size(ARSIZE), .burst(ARBURST),
    .widx(r_widx), .last(r_last), .beat_err(r_err)
  );

  // Write FSM: accept address, take beats (draining surplus beats after a late WLAST), respond.
  always_comb begin
    w_state_d = w_state_q;
    awid_d    = awid_q;
    werr_d    = werr_q;
    drain_d   = drain_q;
    aw_load   = 1'b0;
    w_adv     = 1'b0;
    mem_we    = 1'b0;
    AWREADY   = 1'b0;
    WREADY    = 1'b0;
    BVALID    = 1'b0;
    BRESP     = RESP_OKAY;
    BID       = awid_q;
    case (w_state_q)
      W_IDLE: begin
        AWREADY = 1'b1;
        if (AWVALID) begin
          aw_load   = 1'b1;
          awid_d    = AWID;
          werr_d    = 1'b0;
          drain_d   = 1'b0;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        WREADY = 1'b1;
        if (WVALID) begin
          if (drain_q) begin
            if (WLAST) w_state_d = W_RESP;
          end else begin
            mem_we = !w_err && !ARESET;
            w_adv  = 1'b1;
            if (w_err) werr_d = 1'b1;
            if (WLAST) begin
              if (!w_last) werr_d = 1'b1;
              w_state_d = W_RESP;
            end else if (w_last) begin
              werr_d  = 1'b1;
              drain_d = 1'b1;
            end
          end
        end
      end
      W_RESP: begin
        BVALID = 1'b1;
        BRESP  = werr_q ? RESP_SLVERR : RESP_OKAY;
        if (BREADY) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Read FSM: accept address, stream beats straight from memory, advance only on handshake.
  always_comb begin
    r_state_d = r_state_q;
    arid_d    = arid_q;
    ar_load   = 1'b0;
    r_adv     = 1'b0;
    ARREADY   = 1'b0;
    RVALID    = 1'b0;
    RLAST     = 1'b0;
    RRESP     = RESP_OKAY;
    RDATA     = '0;
    RID       = arid_q;
    case (r_state_q)
      R_IDLE: begin
        ARREADY = 1'b1;
        if (ARVALID) begin
          ar_load   = 1'b1;
          arid_d    = ARID;
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        RVALID = 1'b1;
        RLAST  = r_last;
        RRESP  = r_err ? RESP_SLVERR : RESP_OKAY;
        RDATA  = r_err ? '0 : mem_q[r_widx];
        if (RREADY) begin
          r_adv = 1'b1;
          if (r_last) r_state_d = R_IDLE;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // FSM and latched-ID registers.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      w_state_q <= W_IDLE;
      r_state_q <= R_IDLE;
      awid_q    <= '0;
      arid_q    <= '0;
      werr_q    <= 1'b0;
      drain_q   <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      awid_q    <= awid_d;
      arid_q    <= arid_d;
      werr_q    <= werr_d;
      drain_q   <= drain_d;
    end
  end

  // Byte-enabled memory write; contents deliberately survive reset.
  always_ff @(posedge ACLK) begin
    if (mem_we) begin
      for (int b = 0; b < STRBW; b++) begin
        if (WSTRB[b]) mem_q[w_widx][8*b +: 8] <= WDATA[8*b +: 8];
      end
    end
  end
endmodule

// File: tb/tb_axi_slave_mem.sv
// Self-checking bench for axi_slave_mem: table-driven write/readback plus corner sequences.
module tb_axi_slave_mem;
  import axi_pkg::*;

  logic                 ACLK = 1'b0;
  logic                 ARESET;
  logic                 AWVALID, AWREADY;
  logic [IDW-1:0]       AWID;
  logic [DATAWIDTH-1:0] AWADDR;
  logic [LENW-1:0]      AWLEN;
  logic [SIZE-1:0]      AWSIZE;
  logic [BW-1:0]        AWBURST;
  logic                 WVALID, WREADY;
  logic [IDW-1:0]       WID;
  logic [DATAWIDTH:0]   WDATA;
  logic [STRBW-1:0]     WSTRB;
  logic                 WLAST;
  logic                 BVALID, BREADY;
  logic [IDW-1:0]       BID;
  logic [RW-1:0]        BRESP;
  logic                 ARVALID, ARREADY;
  logic [IDW-1:0]       ARID;
  logic [DATAWIDTH-1:0] ARADDR;
  logic [LENW-1:0]      ARLEN;
  logic [SIZE-1:0]      ARSIZE;
  logic [BW-1:0]        ARBURST;
  logic                 RVALID, RREADY;
  logic [IDW-1:0]       RID;
  logic [DATAWIDTH-1:0] RDATA;
  logic [RW-1:0]        RRESP;
  logic                 RLAST;

  axi_slave_mem #(.DEPTH(256)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWID(AWID), .AWADDR(AWADDR),
    .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .WVALID(WVALID), .WREADY(WREADY), .WID(WID), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST),
    .BVALID(BVALID), .BREADY(BREADY), .BID(BID), .BRESP(BRESP),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .ARID(ARID), .ARADDR(ARADDR),
    .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .RVALID(RVALID), .RREADY(RREADY), .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST)
  );

  // Clock and watchdog
  always #5 ACLK = ~ACLK;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  int n_tests = 0;
  int n_fail  = 0;
  logic [34:0] exp_q[$];          // {rresp, rlast, rdata}
  logic [31:0] model_mem [256];
  logic [31:0] wbuf [16];
  logic [31:0] rexp_d [16];
  logic [1:0]  rexp_r [16];

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    int          nsend;
    logic [3:0]  strb;
    logic [31:0] seed;
    logic [1:0]  exp_bresp;
    bit          do_read;
  } vec_t;
  vec_t vecs [12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int tb_count(input logic [1:0] burst, input logic [3:0] len);
    case (burst)
      2'b00:   return 1;
      2'b01:   return int'(len) + 1;
      default: return 4;
    endcase
  endfunction

  // Closed-form beat address: offset within the wrap window, else linear.
  function automatic logic [31:0] tb_addr(input logic [31:0] start, input logic [2:0] size,
                                          input logic [1:0] burst, input int i);
    logic [31:0] step, win, off;
    step = 32'd1 << size;
    if (burst == 2'b10) begin
      win = step * 4;
      off = ((start % win) + step * i) % win;
      return start - (start % win) + off;
    end
    return start + step * i;
  endfunction

  task automatic fill_rexp_from_model(input logic [31:0] addr, input logic [3:0] len,
                                      input logic [2:0] size, input logic [1:0] burst);
    logic [31:0] a;
    for (int i = 0; i < tb_count(burst, len); i++) begin
      a = tb_addr(addr, size, burst, i);
      if (size > 3'd2 || a[31:2] >= 30'd256) begin
        rexp_d[i] = 32'h0;
        rexp_r[i] = 2'b10;
      end else begin
        rexp_d[i] = model_mem[a[9:2]];
        rexp_r[i] = 2'b00;
      end
    end
  endtask

  task automatic set_rexp4(input logic [31:0] d0, input logic [31:0] d1,
                           input logic [31:0] d2, input logic [31:0] d3);
    rexp_d[0] = d0; rexp_d[1] = d1; rexp_d[2] = d2; rexp_d[3] = d3;
    for (int i = 0; i < 16; i++) rexp_r[i] = 2'b00;
  endtask

  // Write driver: AW, nsend W beats (WLAST on the last sent), then B with optional stall.
  task automatic write_burst(input logic [31:0] addr, input logic [3:0] len, input logic [2:0] size,
                             input logic [1:0] burst, input int nsend, input logic [3:0] strb,
                             input logic [3:0] id, input int bstall, input logic [1:0] exp_resp,
                             input string tag);
    int to;
    int cnt;
    logic [31:0] a;
    cnt = tb_count(burst, len);
    @(posedge ACLK); #1;
    AWVALID = 1'b1; AWID = id; AWADDR = addr; AWLEN = len; AWSIZE = size; AWBURST = burst;
    to = 0;
    do begin @(negedge ACLK); to++; end while (!AWREADY && to < 50);
    check({tag, " awready"}, AWREADY, 1);
    @(posedge ACLK); #1;
    AWVALID = 1'b0;
    for (int i = 0; i < nsend; i++) begin
      WVALID = 1'b1; WID = id; WSTRB = strb; WLAST = (i == nsend - 1);
      WDATA = {1'($urandom_range(0, 1)), wbuf[i]};
      to = 0;
      do begin @(negedge ACLK); to++; end while (!WREADY && to < 50);
      if (!WREADY) begin
        check({tag, " wready_timeout"}, WREADY, 1);
        break;
      end
      @(posedge ACLK); #1;
      if (i < cnt) begin
        a = tb_addr(addr, size, burst, i);
        if (size <= 3'd2 && a[31:2] < 30'd256)
          for (int b = 0; b < 4; b++)
            if (strb[b]) model_mem[a[9:2]][8*b +: 8] = wbuf[i][8*b +: 8];
      end
    end
    WVALID = 1'b0; WLAST = 1'b0;
    to = 0;
    do begin @(negedge ACLK); to++; end while (!BVALID && to < 50);
    check({tag, " bvalid"}, BVALID, 1);
    for (int k = 0; k < bstall; k++) begin
      @(negedge ACLK);
      check({tag, " b_hold"}, {BVALID, BRESP}, {1'b1, exp_resp});
    end
    BREADY = 1'b1;
    check({tag, " bresp"}, BRESP, exp_resp);
    check({tag, " bid"}, BID, id);
    @(posedge ACLK); #1;
    BREADY = 1'b0;
    @(negedge ACLK);
    check({tag, " aw_idle"}, {AWREADY, BVALID}, 2'b10);
  endtask

  // Read driver: expected beats from rexp_* go to the scoreboard, popped per R handshake.
  task automatic read_burst(input logic [31:0] addr, input logic [3:0] len, input logic [2:0] size,
                            input logic [1:0] burst, input logic [3:0] id, input int stall_at,
                            input int stall_n, input string tag);
    int cnt;
    int beat;
    int to;
    logic [34:0] snap;
    logic [34:0] exp;
    cnt = tb_count(burst, len);
    for (int i = 0; i < cnt; i++) exp_q.push_back({rexp_r[i], (i == cnt - 1), rexp_d[i]});
    @(posedge ACLK); #1;
    ARVALID = 1'b1; ARID = id; ARADDR = addr; ARLEN = len; ARSIZE = size; ARBURST = burst;
    to = 0;
    do begin @(negedge ACLK); to++; end while (!ARREADY && to < 50);
    check({tag, " arready"}, ARREADY, 1);
    @(posedge ACLK); #1;
    ARVALID = 1'b0;
    RREADY  = 1'b1;
    beat = 0;
    to   = 0;
    while (beat < cnt && to < 100) begin
      @(negedge ACLK);
      to++;
      if (RVALID) begin
        if (beat == stall_at) begin
          snap   = {RRESP, RLAST, RDATA};
          RREADY = 1'b0;
          repeat (stall_n) begin
            @(negedge ACLK);
            check({tag, " r_hold"}, {RVALID, RRESP, RLAST, RDATA}, {1'b1, snap});
          end
          RREADY = 1'b1;
        end
        exp = exp_q.pop_front();
        check($sformatf("%s rbeat%0d", tag, beat), {RRESP, RLAST, RDATA}, exp);
        check({tag, " rid"}, RID, id);
        beat++;
      end
    end
    if (beat < cnt) begin
      check({tag, " r_timeout_beats"}, beat, cnt);
      exp_q.delete();
    end
    @(posedge ACLK); #1;
    RREADY = 1'b0;
    @(negedge ACLK);
    check({tag, " r_idle"}, {RVALID, ARREADY}, 2'b01);
  endtask

  initial begin
    ARESET = 1'b1;
    AWVALID = 0; AWID = 0; AWADDR = 0; AWLEN = 0; AWSIZE = 0; AWBURST = 0;
    WVALID = 0; WID = 0; WDATA = 0; WSTRB = 0; WLAST = 0; BREADY = 0;
    ARVALID = 0; ARID = 0; ARADDR = 0; ARLEN = 0; ARSIZE = 0; ARBURST = 0; RREADY = 0;

    // Vector table: write transaction and its expected B response.
    vecs[0] = '{32'h10,  4'd0, 3'd2, 2'b00, 1, 4'hF, 32'hDEADBEEF, 2'b00, 1'b1};
    vecs[1] = '{32'h20,  4'd3, 3'd2, 2'b01, 4, 4'hF, 32'h1,        2'b00, 1'b1};
    vecs[2] = '{32'h40,  4'd0, 3'd2, 2'b00, 1, 4'hF, 32'h11223344, 2'b00, 1'b0};
    vecs[3] = '{32'h40,  4'd0, 3'd2, 2'b00, 1, 4'h5, 32'hAABBCCDD, 2'b00, 1'b1};
    vecs[4] = '{32'h0,   4'd0, 3'd2, 2'b00, 1, 4'hF, 32'hCAFEF00D, 2'b00, 1'b1};
    vecs[5] = '{32'h400, 4'd0, 3'd2, 2'b00, 1, 4'hF, 32'h55555555, 2'b10, 1'b1};
    vecs[6] = '{32'h60,  4'd3, 3'd2, 2'b11, 2, 4'hF, 32'hA0,       2'b10, 1'b0};
    vecs[7] = '{32'h80,  4'd1, 3'd2, 2'b01, 3, 4'hF, 32'hB0,       2'b10, 1'b1};
    vecs[8] = '{32'h90,  4'd0, 3'd3, 2'b00, 1, 4'hF, 32'hC0,       2'b10, 1'b1};
    for (int v = 9; v < 12; v++) begin
      vecs[v].addr      = 32'($urandom_range(64, 200)) * 4;
      vecs[v].len       = 4'($urandom_range(0, 7));
      vecs[v].size      = 3'd2;
      vecs[v].burst     = 2'b01;
      vecs[v].nsend     = int'(vecs[v].len) + 1;
      vecs[v].strb      = 4'hF;
      vecs[v].seed      = $urandom;
      vecs[v].exp_bresp = 2'b00;
      vecs[v].do_read   = 1'b1;
    end

    // Reset values
    repeat (2) @(posedge ACLK);
    @(negedge ACLK);
    check("reset_ctrl", {AWREADY, ARREADY, WREADY, BVALID, RVALID, RLAST}, 6'b110000);
    check("reset_data", {BRESP, RRESP, BID, RID, RDATA}, 0);
    @(posedge ACLK); #1;
    ARESET = 1'b0;

    // Table-driven write + readback
    for (int v = 0; v < 12; v++) begin
      for (int i = 0; i < 16; i++) wbuf[i] = vecs[v].seed + 32'(i);
      write_burst(vecs[v].addr, vecs[v].len, vecs[v].size, vecs[v].burst, vecs[v].nsend,
                  vecs[v].strb, 4'(v), 0, vecs[v].exp_bresp, $sformatf("vec%0d", v));
      if (vecs[v].do_read) begin
        fill_rexp_from_model(vecs[v].addr, vecs[v].len, vecs[v].size, vecs[v].burst);
        read_burst(vecs[v].addr, vecs[v].len, vecs[v].size, vecs[v].burst, 4'(15 - v), -1, 0,
                   $sformatf("vec%0d_rd", v));
      end
    end

    // Explicit-value readbacks
    set_rexp4(32'd3, 32'd4, 32'd1, 32'd2);
    read_burst(32'h28, 4'd0, 3'd2, 2'b10, 4'h5, -1, 0, "wrap4_rd");
    set_rexp4(32'd1, 32'd2, 32'd3, 32'd4);
    read_burst(32'h20, 4'd0, 3'd2, 2'b11, 4'h6, -1, 0, "incr4_rd");
    set_rexp4(32'h11BB33DD, 0, 0, 0);
    read_burst(32'h40, 4'd0, 3'd2, 2'b00, 4'h7, -1, 0, "strb_rd");
    set_rexp4(32'hCAFEF00D, 0, 0, 0);
    read_burst(32'h0, 4'd0, 3'd2, 2'b00, 4'h8, -1, 0, "oob_alias_rd");
    set_rexp4(32'hA0, 32'hA1, 0, 0);
    read_burst(32'h60, 4'd1, 3'd2, 2'b01, 4'h9, -1, 0, "early_wlast_rd");

    // Stalls: RREADY low 5 cycles mid-burst, BREADY low 3 cycles
    set_rexp4(32'd1, 32'd2, 32'd3, 32'd4);
    read_burst(32'h20, 4'd0, 3'd2, 2'b11, 4'hA, 1, 5, "rstall");
    wbuf[0] = 32'h12345678;
    write_burst(32'h30, 4'd0, 3'd2, 2'b00, 1, 4'hF, 4'hB, 3, 2'b00, "bstall");
    set_rexp4(32'h12345678, 0, 0, 0);
    read_burst(32'h30, 4'd0, 3'd2, 2'b00, 4'hC, -1, 0, "bstall_rd");

    // Reset mid-burst: first beat kept, pending burst abandoned
    @(posedge ACLK); #1;
    AWVALID = 1'b1; AWID = 4'hD; AWADDR = 32'hA0; AWLEN = 0; AWSIZE = 3'd2; AWBURST = 2'b11;
    @(negedge ACLK);
    check("rst_mid awready", AWREADY, 1);
    @(posedge ACLK); #1;
    AWVALID = 1'b0; WVALID = 1'b1; WDATA = 33'h0_0000_0777; WSTRB = 4'hF; WLAST = 1'b0;
    @(negedge ACLK);
    check("rst_mid wready", WREADY, 1);
    @(posedge ACLK); #1;
    WVALID = 1'b0; ARESET = 1'b1;
    @(posedge ACLK); #1;
    ARESET = 1'b0;
    @(negedge ACLK);
    check("rst_mid idle", {AWREADY, WREADY, BVALID}, 3'b100);
    set_rexp4(32'h777, 0, 0, 0);
    read_burst(32'hA0, 4'd0, 3'd2, 2'b00, 4'hE, -1, 0, "rst_mid_rd");

    check("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
